header_tx_sequencer_ble: RTL and testbench
==========================================

HEADER_TX_SEQUENCER_BLE -- requirements
Module: header_tx_sequencer_ble

Interface
REQ-001 SHALL have parameter HDR_BITS, 10, header field bits serialized per packet (1..16).
REQ-002 SHALL have parameter EXP_SYMS, 27, mapper output symbols expected per header ((HDR_BITS+8)*3/2).
REQ-003 SHALL have parameter TMO_CYC, 1023, WAIT-state timeout in clock cycles (10-bit counter).
REQ-004 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port start, input, 1, one-cycle request to transmit a header.
REQ-007 SHALL have port abort, input, 1, cancel the current header.
REQ-008 SHALL have port hdr_fields, input, 16, header bits; only [HDR_BITS-1:0] used.
REQ-009 SHALL have port uap_in, input, 8, upper address part for HEC seed.
REQ-010 SHALL have port chain_valid_out, input, 1, symbol-valid strobe from the header mapper.
REQ-011 SHALL have port chain_valid_in, output, 1, bit-valid to the header chain.
REQ-012 SHALL have port chain_data_in, output, 1, serial header bit to the header chain.
REQ-013 SHALL have port uap_out, output, 8, UAP held stable to the HEC for the whole packet.
REQ-014 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-015 SHALL have port done, output, 1, one-cycle pulse on successful completion.
REQ-016 SHALL have port timeout, output, 1, one-cycle pulse on WAIT timeout.
REQ-017 SHALL have port sym_count, output, 8, mapper symbols counted for the current header.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, SHIFT, WAIT, DONE.
REQ-019 IDLE: start=1 SHALL latch hdr_fields into shift register and uap_in into uap_out, clear sym_count, go to LOAD.
REQ-020 LOAD SHALL last exactly one cycle (HEC seed setup) with chain_valid_in=0, then go to SHIFT.
REQ-021 SHIFT SHALL drive chain_valid_in=1 for exactly HDR_BITS consecutive cycles, LSB first, then go to WAIT.
REQ-022 sym_count SHALL increment on each chain_valid_out=1 in SHIFT or WAIT, saturating at 255.
REQ-023 WAIT SHALL go to DONE the cycle after sym_count reaches EXP_SYMS.
REQ-024 DONE SHALL assert done for one cycle, then go to IDLE; latency start-to-done is HDR_BITS+2 cycles plus mapper drain.
REQ-025 start while busy=1 SHALL be ignored (no queueing).
REQ-026 abort=1 in any non-IDLE state SHALL force IDLE next cycle, chain_valid_in=0 that cycle; no done/timeout pulse.
REQ-027 abort and start in the same IDLE cycle: abort SHALL win; stay IDLE.
REQ-028 chain_valid_in and chain_data_in SHALL be registered outputs; chain_data_in=0 when chain_valid_in=0.
REQ-029 uap_out SHALL change only on accepted start.
REQ-030 chain_valid_out while IDLE SHALL be ignored.

Reset
REQ-031 reset=1 SHALL immediately force IDLE and clear shift register, counters, chain_valid_in, chain_data_in, busy, done, timeout to 0 and uap_out to 8'h00.
REQ-032 reset mid-SHIFT SHALL drop chain_valid_in asynchronously; no pulse on release.

Configuration
REQ-033 Macro HDR_SEQ_TIMEOUT_EN defined: 10-bit WAIT counter, cleared on WAIT entry and on each chain_valid_out; reaching TMO_CYC pulses timeout one cycle and forces IDLE.
REQ-034 Macro HDR_SEQ_TIMEOUT_EN undefined: no timeout counter; timeout tied 0; WAIT exits only via EXP_SYMS or abort.

Verification
REQ-035 hdr_fields=16'h02A5, uap_in=8'h47, start -> after LOAD chain_data_in = 1,0,1,0,0,1,0,1,0,1 over 10 cycles, uap_out=8'h47.
REQ-036 Feed 27 chain_valid_out strobes after SHIFT -> sym_count=27, done pulses once, busy falls next cycle.
REQ-037 start re-pulsed at 4th SHIFT cycle -> serial stream unchanged, single done.
REQ-038 abort at 6th SHIFT cycle -> IDLE next cycle, chain_valid_in=0, no done.
REQ-039 With HDR_SEQ_TIMEOUT_EN, TMO_CYC=1023, only 20 strobes -> timeout pulse 1023 cycles after last strobe, busy=0; without macro -> stays WAIT.
REQ-040 reset asserted mid-WAIT -> all outputs 0 immediately; after release, next start runs normally.

Source files
------------

// File: rtl/header_tx_sequencer_ble.sv
// header_tx_sequencer_ble
// Sequences one packet header into the header chain. The chain is the
// HEC/FEC/mapper path. The block latches the header fields and the UAP,
// spends one cycle on HEC seed setup, and then shifts HDR_BITS bits out
// LSB first. It then waits until the mapper has produced EXP_SYMS symbols.
//
// Optional feature: define HDR_SEQ_TIMEOUT_EN to enable a WAIT-state
// watchdog. If no mapper symbol arrives for TMO_CYC cycles, the block pulses
// timeout and returns to IDLE. Without the macro, WAIT leaves only through
// symbol completion or abort.

module header_tx_sequencer_ble #(
  parameter int HDR_BITS = 10,
  parameter int EXP_SYMS = 27,
  parameter int TMO_CYC  = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] hdr_fields,
  input  logic [7:0]  uap_in,
  input  logic        chain_valid_out,
  output logic        chain_valid_in,
  output logic        chain_data_in,
  output logic [7:0]  uap_out,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [7:0]  sym_count
);

  localparam logic [4:0]  HDR_BITS_C = 5'(HDR_BITS);
  localparam logic [7:0]  EXP_SYMS_C = 8'(EXP_SYMS);
  localparam logic [15:0] HDR_MASK   = 16'((32'd1 << HDR_BITS) - 32'd1);

  // Reject parameter values the counters cannot represent.
  if (HDR_BITS < 1 || HDR_BITS > 16) begin : g_bad_hdr_bits
    $error("header_tx_sequencer_ble: HDR_BITS must be 1..16");
  end
  if (EXP_SYMS < 1 || EXP_SYMS > 255) begin : g_bad_exp_syms
    $error("header_tx_sequencer_ble: EXP_SYMS must be 1..255");
  end
  if (TMO_CYC < 1 || TMO_CYC > 1023) begin : g_bad_tmo_cyc
    $error("header_tx_sequencer_ble: TMO_CYC must be 1..1023");
  end

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    WAIT,
    DONE
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [15:0] shift_q;
  logic [4:0]  bit_cnt;
  logic        accept;
  logic        emit;
  logic        count_sym;
  logic        tmo_fire;

  // An accepted start is only possible from IDLE. Abort overrides it.
  assign accept    = (state_q == IDLE) && start && !abort;
  // A bit goes on the chain in every cycle that the FSM spends in SHIFT.
  assign emit      = (state_d == SHIFT);
  assign count_sym = chain_valid_out && ((state_q == SHIFT) || (state_q == WAIT)) &&
                     (sym_count != 8'hFF);

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

`ifdef HDR_SEQ_TIMEOUT_EN
  localparam logic [9:0] TMO_LAST = 10'(TMO_CYC - 1);

  logic [9:0] tmo_cnt;

  // The watchdog fires when the idle-cycle count would reach TMO_CYC.
  // Completion and abort both take priority over it.
  assign tmo_fire = (state_q == WAIT) && !chain_valid_out && (tmo_cnt == TMO_LAST) &&
                    !abort && (sym_count < EXP_SYMS_C);

  // Watchdog: counts idle WAIT cycles. The count restarts on every symbol
  // and is held at zero outside WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
      timeout <= 1'b0;
    end else begin
      if ((state_q != WAIT) || chain_valid_out) tmo_cnt <= '0;
      else                                      tmo_cnt <= tmo_cnt + 10'd1;
      timeout <= tmo_fire;
    end
  end
`else
  assign tmo_fire = 1'b0;
  assign timeout  = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      // NOTE: clocked state uses non-blocking assignment. All flops then
      // sample pre-edge values, so the flops cannot race each other.
      state_q <= state_d;
    end
  end

  // Next-state logic. Abort forces IDLE from any state.
  always_comb begin
    // NOTE: assign the default before the case statement. Every path then
    // drives state_d, so no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = SHIFT;
      SHIFT:   if (bit_cnt == HDR_BITS_C) state_d = WAIT;
      WAIT: begin
        if (sym_count >= EXP_SYMS_C) state_d = DONE;
        else if (tmo_fire)           state_d = IDLE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  // Header datapath: latch on accept, shift one bit per SHIFT cycle.
  // The chain outputs are registered and are zero whenever valid is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the shift register is cleared on reset along with the control
      // state. A stale header must never be seen on the chain after reset.
      shift_q        <= '0;
      bit_cnt        <= '0;
      uap_out        <= 8'h00;
      chain_valid_in <= 1'b0;
      chain_data_in  <= 1'b0;
    end else begin
      if (accept) begin
        shift_q <= hdr_fields & HDR_MASK;
        uap_out <= uap_in;
        bit_cnt <= '0;
      end else if (emit) begin
        shift_q <= shift_q >> 1;
        bit_cnt <= bit_cnt + 5'd1;
      end
      chain_valid_in <= emit;
      chain_data_in  <= emit & shift_q[0];
    end
  end

  // Mapper symbol counter: cleared on accept, saturates at 255.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sym_count <= 8'h00;
    end else if (accept) begin
      sym_count <= 8'h00;
    end else if (count_sym) begin
      sym_count <= sym_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_header_tx_sequencer_ble.sv
// Self-checking bench for header_tx_sequencer_ble.
// The driver pushes the expected serial bits and the expected completions
// into queues. A negedge monitor pops them and compares them against the DUT.

module tb_header_tx_sequencer_ble;

  localparam int HDR_BITS = 10;
  localparam int EXP_SYMS = 27;
  localparam int TMO_CYC  = 1023;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [15:0] hdr_fields;
  logic [7:0]  uap_in;
  logic        chain_valid_out;
  logic        chain_valid_in;
  logic        chain_data_in;
  logic [7:0]  uap_out;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [7:0]  sym_count;

  header_tx_sequencer_ble #(
    .HDR_BITS(HDR_BITS),
    .EXP_SYMS(EXP_SYMS),
    .TMO_CYC (TMO_CYC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .hdr_fields     (hdr_fields),
    .uap_in         (uap_in),
    .chain_valid_out(chain_valid_out),
    .chain_valid_in (chain_valid_in),
    .chain_data_in  (chain_data_in),
    .uap_out        (uap_out),
    .busy           (busy),
    .done           (done),
    .timeout        (timeout),
    .sym_count      (sym_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       b;
    logic [7:0] uap;
  } bit_exp_t;

  bit_exp_t bitq[$];
  int       doneq[$];
  int       checks = 0;
  int       errors = 0;
  int       done_seen = 0;
  logic     busy_pending = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the DUT against the scoreboard queues.
  always @(negedge clk) begin
    if (!reset) begin
      if (busy_pending) begin
        check("busy_after_done", 32'(busy), 32'd0);
        busy_pending = 1'b0;
      end
      if (chain_valid_in) begin
        if (bitq.size() == 0) begin
          check("extra_valid_bit", 32'(chain_valid_in), 32'd0);
        end else begin
          bit_exp_t e;
          e = bitq.pop_front();
          check("serial_bit", 32'(chain_data_in), 32'(e.b));
          check("uap_stable", 32'(uap_out), 32'(e.uap));
        end
      end else begin
        check("data_zero_when_invalid", 32'(chain_data_in), 32'd0);
      end
      if (done) begin
        done_seen++;
        if (doneq.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          int exp_syms;
          exp_syms = doneq.pop_front();
          check("sym_count_at_done", 32'(sym_count), 32'(exp_syms));
          check("bits_left_at_done", 32'(bitq.size()), 32'd0);
          busy_pending = 1'b1;
        end
      end
`ifndef HDR_SEQ_TIMEOUT_EN
      check("timeout_tied_low", 32'(timeout), 32'd0);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the packet emits bit i of the header on the i-th
  // valid cycle, for nbits cycles, with the latched UAP held throughout.
  task automatic start_pkt(input logic [15:0] hdr, input logic [7:0] uap, input int nbits);
    for (int i = 0; i < nbits; i++) bitq.push_back('{hdr[i], uap});
    hdr_fields = hdr;
    uap_in     = uap;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    hdr_fields = 16'($urandom);
    uap_in     = 8'($urandom);
    check("load_busy", 32'(busy), 32'd1);
    check("load_no_valid", 32'(chain_valid_in), 32'd0);
    check("uap_latched", 32'(uap_out), 32'(uap));
    tick();
    check("first_bit_latency", 32'(chain_valid_in), 32'd1);
  endtask

  task automatic feed_strobes(input int n, input int max_gap);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(max_gap, 0)) tick();
      chain_valid_out = 1'b1;
      tick();
      chain_valid_out = 1'b0;
    end
  endtask

  task automatic wait_done(input int budget);
    int base;
    int n;
    base = done_seen;
    n    = 0;
    while (done_seen == base && n < budget) begin
      tick();
      n++;
    end
    check("done_within_budget", 32'(done_seen - base), 32'd1);
  endtask

  task automatic run_packet(input logic [15:0] hdr, input logic [7:0] uap, input int max_gap);
    doneq.push_back(EXP_SYMS);
    start_pkt(hdr, uap, HDR_BITS);
    feed_strobes(EXP_SYMS, max_gap);
    wait_done(40);
    tick();
    tick();
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin : driver
    logic [7:0] prev_uap;
    reset           = 1'b1;
    start           = 1'b0;
    abort           = 1'b0;
    hdr_fields      = 16'h0;
    uap_in          = 8'h0;
    chain_valid_out = 1'b0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(chain_valid_in), 32'd0);
    check("rst_data", 32'(chain_data_in), 32'd0);
    check("rst_uap", 32'(uap_out), 32'd0);
    check("rst_sym", 32'(sym_count), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    #5 reset = 1'b0;
    tick();

    // Mapper strobes in IDLE must not be counted.
    chain_valid_out = 1'b1;
    repeat (3) tick();
    chain_valid_out = 1'b0;
    check("idle_strobes_ignored", 32'(sym_count), 32'd0);
    check("idle_not_busy", 32'(busy), 32'd0);

    // Directed header: 0x2A5 is sent LSB first as 1,0,1,0,0,1,0,1,0,1.
    run_packet(16'h02A5, 8'h47, 2);
    check("directed_uap_held", 32'(uap_out), 32'h47);
    check("directed_sym_count", 32'(sym_count), 32'(EXP_SYMS));

    // Randomised headers, UAPs and symbol spacing.
    for (int k = 0; k < 8; k++) begin
      run_packet(16'($urandom), 8'($urandom), k % 4);
    end

    // Start re-pulsed in the 4th SHIFT cycle must be ignored.
    doneq.push_back(EXP_SYMS);
    start_pkt(16'h0333, 8'h5A, HDR_BITS);
    repeat (3) tick();
    hdr_fields = 16'hFFFF;
    uap_in     = 8'hEE;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    check("repulse_uap_unchanged", 32'(uap_out), 32'h5A);
    feed_strobes(EXP_SYMS, 1);
    wait_done(40);
    repeat (20) tick();
    check("repulse_idle_after", 32'(busy), 32'd0);

    // Abort in the 6th SHIFT cycle: only bits 0..5 leave, no done follows.
    start_pkt(16'($urandom), 8'($urandom), 6);
    repeat (5) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle", 32'(busy), 32'd0);
    check("abort_valid_low", 32'(chain_valid_in), 32'd0);
    repeat (40) tick();
    check("abort_bits_consumed", 32'(bitq.size()), 32'd0);

    // Abort and start in the same IDLE cycle: abort wins.
    prev_uap   = uap_out;
    uap_in     = ~prev_uap;
    hdr_fields = 16'h1234;
    start      = 1'b1;
    abort      = 1'b1;
    tick();
    start      = 1'b0;
    abort      = 1'b0;
    check("abort_start_idle", 32'(busy), 32'd0);
    check("abort_start_uap", 32'(uap_out), 32'(prev_uap));
    repeat (3) tick();

    // Too few symbols: WAIT either times out or stays put.
    start_pkt(16'($urandom), 8'($urandom), HDR_BITS);
    repeat (10) tick();
    feed_strobes(20, 2);
    check("short_sym_count", 32'(sym_count), 32'd20);
`ifdef HDR_SEQ_TIMEOUT_EN
    repeat (TMO_CYC - 1) tick();
    check("tmo_not_yet", 32'(timeout), 32'd0);
    check("tmo_still_busy", 32'(busy), 32'd1);
    tick();
    check("tmo_pulse", 32'(timeout), 32'd1);
    check("tmo_idle", 32'(busy), 32'd0);
    tick();
    check("tmo_one_cycle", 32'(timeout), 32'd0);
`else
    repeat (TMO_CYC + 80) tick();
    check("wait_holds_busy", 32'(busy), 32'd1);
    check("wait_holds_count", 32'(sym_count), 32'd20);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("wait_abort_idle", 32'(busy), 32'd0);
`endif
    repeat (3) tick();

    // Asynchronous reset in WAIT clears everything before the next edge.
    start_pkt(16'($urandom), 8'($urandom), HDR_BITS);
    repeat (10) tick();
    feed_strobes(10, 1);
    #2 reset = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_sym", 32'(sym_count), 32'd0);
    check("midrst_uap", 32'(uap_out), 32'd0);
    check("midrst_valid", 32'(chain_valid_in), 32'd0);
    check("midrst_data", 32'(chain_data_in), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_timeout", 32'(timeout), 32'd0);
    #13 reset = 1'b0;
    tick();
    check("post_rst_idle", 32'(busy), 32'd0);
    run_packet(16'($urandom), 8'($urandom), 2);

    repeat (5) tick();
    check("final_queues_empty", 32'(bitq.size() + doneq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
